// File: rtl/pixel_block_vote.sv
// pixel_block_vote: majority-vote downsampler for the 1-bit camera stream.
// Each non-overlapping BLOCK x BLOCK tile of the IN_WIDTH x IN_HEIGHT raster
// is reduced to one output pixel (ones-count >= THRESH) plus its density.
//
// Ports:
//   clk_in          system clock
//   rst_in          asynchronous active-high reset
//   hcount_in       input column
//   vcount_in       input row
//   pixel_in        B/W pixel, 1 = foreground
//   data_valid_in   strobe qualifying hcount_in/vcount_in/pixel_in
//   pixel_out       block vote result
//   density_out     ones-count of the emitted block
//   hcount_out      block column
//   vcount_out      block row
//   data_valid_out  one-cycle strobe qualifying all outputs
module pixel_block_vote #(
    parameter int IN_WIDTH  = 240,
    parameter int IN_HEIGHT = 320,
    parameter int BLOCK     = 10,
    parameter int THRESH    = 50
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        pixel_in,
    input  logic        data_valid_in,
    output logic        pixel_out,
    output logic [6:0]  density_out,
    output logic [4:0]  hcount_out,
    output logic [4:0]  vcount_out,
    output logic        data_valid_out
);

    localparam int NBX   = IN_WIDTH / BLOCK;
    localparam int SW    = $clog2(BLOCK);
    localparam int ACC_W = 7;

    // Stage 1: block coordinates and position within the block.
    logic          s1_valid;
    logic [4:0]    s1_bx;
    logic [4:0]    s1_by;
    logic [SW-1:0] s1_sx;
    logic [SW-1:0] s1_sy;
    logic          s1_pix;

    logic in_range;
    assign in_range = data_valid_in
                   && (hcount_in < 11'(IN_WIDTH))
                   && (vcount_in < 10'(IN_HEIGHT));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            s1_valid <= 1'b0;
            s1_bx    <= '0;
            s1_by    <= '0;
            s1_sx    <= '0;
            s1_sy    <= '0;
            s1_pix   <= 1'b0;
        end else begin
            s1_valid <= in_range;
            if (in_range) begin
                s1_bx  <= 5'(hcount_in / 11'(BLOCK));
                s1_by  <= 5'(vcount_in / 10'(BLOCK));
                s1_sx  <= SW'(hcount_in % 11'(BLOCK));
                s1_sy  <= SW'(vcount_in % 10'(BLOCK));
                s1_pix <= pixel_in;
            end
        end
    end

    // Stage 2: one accumulator per block column; a whole block row of tiles
    // is in flight at once while the raster sweeps across it.
    logic [ACC_W-1:0] acc [NBX];
    logic [ACC_W-1:0] acc_cur;
    logic [ACC_W-1:0] total;
    logic             first;
    logic             last;

    always_comb begin
        acc_cur = acc[s1_bx];
        total   = acc_cur + ACC_W'(s1_pix);
        first   = (s1_sx == SW'(0)) && (s1_sy == SW'(0));
        last    = (s1_sx == SW'(BLOCK - 1)) && (s1_sy == SW'(BLOCK - 1));
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < NBX; i++) begin
                acc[i] <= '0;
            end
            pixel_out      <= 1'b0;
            density_out    <= '0;
            hcount_out     <= '0;
            vcount_out     <= '0;
            data_valid_out <= 1'b0;
        end else begin
            data_valid_out <= 1'b0;
            if (s1_valid) begin
                if (first) begin
                    // Load rather than add: discards any stale partial sum,
                    // so no frame-start marker is needed.
                    acc[s1_bx] <= ACC_W'(s1_pix);
                end else if (last) begin
                    acc[s1_bx]     <= '0;
                    pixel_out      <= (total >= ACC_W'(THRESH));
                    density_out    <= total;
                    hcount_out     <= s1_bx;
                    vcount_out     <= s1_by;
                    data_valid_out <= 1'b1;
                end else begin
                    acc[s1_bx] <= total;
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_block_vote.sv
// Self-checking bench for pixel_block_vote. Drives whole block rows (bands of
// 10 input rows) from a vector table and compares every emitted strobe
// against a direct 10x10 count of the stimulus image, plus hand sequences for
// latency, mid-frame asynchronous reset and stale partial sums.
module tb_pixel_block_vote;

    localparam int NBX = 24;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        pixel;
    logic        dv_in;
    logic        pixel_out;
    logic [6:0]  density_out;
    logic [4:0]  hcount_out;
    logic [4:0]  vcount_out;
    logic        data_valid_out;

    pixel_block_vote dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .hcount_in      (hcount),
        .vcount_in      (vcount),
        .pixel_in       (pixel),
        .data_valid_in  (dv_in),
        .pixel_out      (pixel_out),
        .density_out    (density_out),
        .hcount_out     (hcount_out),
        .vcount_out     (vcount_out),
        .data_valid_out (data_valid_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mode;   // 0 zeros, 1 ones, 2 graded threshold, 3 random, 4 lower half
        int by;
        bit gaps;
        bit oor;
        int seed;
        int hb;     // block column with a hand-computed result, -1 for none
        int ed;
        bit ep;
    } vec_t;

    typedef struct {
        int h;
        int v;
        bit p;
        int d;
    } strobe_t;

    strobe_t q[$];
    int total = 0;
    int bad   = 0;

    always @(negedge clk) begin
        if (data_valid_out === 1'b1)
            q.push_back('{int'(hcount_out), int'(vcount_out), pixel_out, int'(density_out)});
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit pix(input int mode, input int x, input int y, input int seed);
        int bx;
        int li;
        int n;
        int unsigned h;
        bx = x / 10;
        li = (y % 10) * 10 + (x % 10);
        case (mode)
            0: return 1'b0;
            1: return 1'b1;
            2: begin
                n = (bx == 0) ? 50 : (bx == 1) ? 49 : bx * 4;
                return li < n;
            end
            4: return (y % 10) >= 5;
            default: begin
                h = (x * 32'd73856093) ^ (y * 32'd19349663) ^ seed;
                h = h ^ (h >> 13);
                h = h * 32'h5bd1e995;
                h = h ^ (h >> 15);
                return h[7];
            end
        endcase
    endfunction

    function automatic int count(input int mode, input int bx, input int by, input int seed);
        int c = 0;
        for (int y = 0; y < 10; y++)
            for (int x = 0; x < 10; x++)
                c += int'(pix(mode, bx * 10 + x, by * 10 + y, seed));
        return c;
    endfunction

    task automatic put(input int x, input int y, input bit p);
        @(posedge clk);
        #1;
        hcount = 11'(x);
        vcount = 10'(y);
        pixel  = p;
        dv_in  = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            dv_in = 1'b0;
        end
    endtask

    task automatic feed(input int mode, input int by, input int r0, input int r1,
                        input bit gaps, input bit oor, input int seed);
        for (int y = by * 10 + r0; y <= by * 10 + r1; y++) begin
            for (int x = 0; x < 240; x++) begin
                put(x, y, pix(mode, x, y, seed));
                if (oor) begin
                    put(300, y, 1'b1);
                    put(x, 400, 1'b1);
                end
                if (gaps) idle(int'($urandom_range(0, 3)));
            end
        end
        idle(4);
    endtask

    task automatic compare_band(input int by, input int mode, input int seed,
                                input int hb, input int ed, input bit ep);
        int d;
        check($sformatf("band%0d_strobes", by), q.size(), NBX);
        for (int i = 0; i < NBX && i < q.size(); i++) begin
            d = count(mode, i, by, seed);
            check($sformatf("b%0d_%0d_h", by, i), q[i].h, i);
            check($sformatf("b%0d_%0d_v", by, i), q[i].v, by);
            check($sformatf("b%0d_%0d_d", by, i), q[i].d, d);
            check($sformatf("b%0d_%0d_p", by, i), int'(q[i].p), int'(d >= 50));
        end
        if (hb >= 0 && hb < q.size()) begin
            check($sformatf("hand_b%0d_%0d_d", by, hb), q[hb].d, ed);
            check($sformatf("hand_b%0d_%0d_p", by, hb), int'(q[hb].p), int'(ep));
        end
        q.delete();
    endtask

    vec_t tbl[8];

    initial begin
        tbl[0] = '{0, 0,  1'b0, 1'b0, 0,       0,  0,   1'b0};
        tbl[1] = '{1, 0,  1'b0, 1'b0, 0,       5,  100, 1'b1};
        tbl[2] = '{2, 1,  1'b0, 1'b0, 0,       0,  50,  1'b1};
        tbl[3] = '{2, 1,  1'b0, 1'b0, 0,       1,  49,  1'b0};
        tbl[4] = '{1, 31, 1'b0, 1'b0, 0,       23, 100, 1'b1};
        tbl[5] = '{3, 5,  1'b1, 1'b0, 32'h1234, -1, 0,  1'b0};
        tbl[6] = '{3, 7,  1'b0, 1'b1, 32'h77,  -1, 0,   1'b0};
        tbl[7] = '{2, 12, 1'b1, 1'b1, 0,       13, 52,  1'b1};

        rst    = 1'b1;
        hcount = '0;
        vcount = '0;
        pixel  = 1'b0;
        dv_in  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dv", int'(data_valid_out), 0);
        check("rst_p", int'(pixel_out), 0);
        check("rst_d", int'(density_out), 0);
        check("rst_h", int'(hcount_out), 0);
        check("rst_v", int'(vcount_out), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Latency: block (0,0) all ones, corner driven after edge E0.
        for (int y = 0; y < 10; y++)
            for (int x = 0; x < 10; x++)
                if (!(x == 9 && y == 9)) put(x, y, 1'b1);
        put(9, 9, 1'b1);
        @(negedge clk);
        check("lat_e0", int'(data_valid_out), 0);
        @(posedge clk);
        #1;
        dv_in = 1'b0;
        @(negedge clk);
        check("lat_e1", int'(data_valid_out), 0);
        @(negedge clk);
        check("lat_e2", int'(data_valid_out), 1);
        check("lat_d", int'(density_out), 100);
        check("lat_p", int'(pixel_out), 1);
        @(negedge clk);
        check("lat_e3", int'(data_valid_out), 0);
        check("hold_d", int'(density_out), 100);
        check("hold_p", int'(pixel_out), 1);
        q.delete();

        // Reset mid-frame, asserted between clock edges.
        feed(1, 0, 0, 4, 1'b0, 1'b0, 0);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_d", int'(density_out), 0);
        check("mid_rst_p", int'(pixel_out), 0);
        check("mid_rst_dv", int'(data_valid_out), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        feed(4, 0, 5, 9, 1'b0, 1'b0, 0);
        compare_band(0, 4, 0, 0, 50, 1'b1);

        // Frame started mid-block: leaves partial sums with no corner.
        feed(1, 0, 3, 6, 1'b0, 1'b0, 0);
        check("stale_no_strobe", q.size(), 0);

        for (int i = 0; i < 8; i++) begin
            feed(tbl[i].mode, tbl[i].by, 0, 9, tbl[i].gaps, tbl[i].oor, tbl[i].seed);
            compare_band(tbl[i].by, tbl[i].mode, tbl[i].seed, tbl[i].hb, tbl[i].ed, tbl[i].ep);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
